// File: rtl/funcion_lut_seq_if.sv
// Bus bundle for funcion_lut_seq: table load, single evaluation, sweep control
// and the result/count outputs. The master drives requests and the slave answers.
interface funcion_lut_seq_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
);
  // Requests carry no ready signal. cfg_we, in_valid and sweep_start are
  // single-cycle strobes that are accepted only while busy is low. While busy
  // is high they are dropped, not queued. out_valid marks one result per cycle.
  logic                          cfg_we;
  logic [N_IN-1:0]               cfg_addr;
  logic [N_OUT-1:0]              cfg_data;
  logic                          in_valid;
  logic [N_IN-1:0]               in_vec;
  logic                          sweep_start;
  logic                          out_valid;
  logic [N_OUT-1:0]              out_vec;
  logic [N_IN-1:0]               out_idx;
  logic                          busy;
  logic                          sweep_done;
  logic [N_OUT*(N_IN+1)-1:0]     minterm_cnt;

  modport master (
    output cfg_we, cfg_addr, cfg_data, in_valid, in_vec, sweep_start,
    input  out_valid, out_vec, out_idx, busy, sweep_done, minterm_cnt
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, in_valid, in_vec, sweep_start,
    output out_valid, out_vec, out_idx, busy, sweep_done, minterm_cnt
  );
endinterface

// File: rtl/funcion_lut_seq.sv
// Runtime-loadable truth table of N_OUT functions of N_IN inputs with
// one-cycle evaluation and an exhaustive sweep that counts each function's ones.
module funcion_lut_seq #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  funcion_lut_seq_if.slave    bus,
  output logic [1:0]          o_dbg_state
);
  localparam int DEPTH = 2**N_IN;
  localparam int CW    = N_IN + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SWEEP = 2'd1, S_DONE = 2'd2} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [N_OUT-1:0]    r_table [DEPTH];
  logic [CW-1:0]       r_idx;
  logic [CW-1:0]       r_cnt [N_OUT];
  logic                r_out_valid;
  logic [N_OUT-1:0]    r_out_vec;
  logic [N_IN-1:0]     r_out_idx;
  logic                r_sweep_done;
  logic [N_IN-1:0]     w_sidx;

  assign w_sidx = r_idx[N_IN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.sweep_start) w_next = S_SWEEP;
      S_SWEEP: if (r_idx == LAST)   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Reads use the pre-edge table contents, so a same-cycle write to the
  // evaluated address returns the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) r_table[a] <= '0;
      for (int j = 0; j < N_OUT; j++) r_cnt[j] <= '0;
      r_idx        <= '0;
      r_out_valid  <= 1'b0;
      r_out_vec    <= '0;
      r_out_idx    <= '0;
      r_sweep_done <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_sweep_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cfg_we) r_table[bus.cfg_addr] <= bus.cfg_data;
          if (bus.sweep_start) begin
            r_idx <= '0;
            for (int j = 0; j < N_OUT; j++) r_cnt[j] <= '0;
          end else if (bus.in_valid) begin
            r_out_vec   <= r_table[bus.in_vec];
            r_out_idx   <= bus.in_vec;
            r_out_valid <= 1'b1;
          end
        end
        S_SWEEP: begin
          r_out_vec   <= r_table[w_sidx];
          r_out_idx   <= w_sidx;
          r_out_valid <= 1'b1;
          for (int j = 0; j < N_OUT; j++)
            r_cnt[j] <= r_cnt[j] + CW'(r_table[w_sidx][j]);
          r_idx <= r_idx + CW'(1);
        end
        S_DONE: r_sweep_done <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.minterm_cnt = '0;
    for (int j = 0; j < N_OUT; j++) bus.minterm_cnt[j*CW +: CW] = r_cnt[j];
  end

  // DONE still counts as busy, so requests in that cycle are dropped.
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.out_valid  = r_out_valid;
  assign bus.out_vec    = r_out_vec;
  assign bus.out_idx    = r_out_idx;
  assign bus.sweep_done = r_sweep_done;
  assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_funcion_lut_seq.sv
// Directed bench for funcion_lut_seq with N_IN=4, N_OUT=3.
module tb_funcion_lut_seq;
  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int W     = N_OUT;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_fail;
  logic [W-1:0] exp_q[$];

  funcion_lut_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  funcion_lut_seq #(.N_IN(N_IN), .N_OUT(N_OUT)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_fn(input logic [N_IN-1:0] a);
    return {1'b1, a[3] & a[2], a[0]};
  endfunction

  // driver tasks
  task automatic idle_inputs();
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.in_valid = 1'b0; bus.in_vec = '0; bus.sweep_start = 1'b0;
  endtask

  task automatic write_entry(input logic [N_IN-1:0] a, input logic [W-1:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic eval_check(input string tag, input logic [N_IN-1:0] v, input logic [W-1:0] exp);
    bus.in_valid = 1'b1; bus.in_vec = v;
    tick();
    bus.in_valid = 1'b0;
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_vec"}, 32'(bus.out_vec), 32'(exp));
    check_eq({tag, "_idx"}, 32'(bus.out_idx), 32'(v));
  endtask

  task automatic run_sweep(input bit inject);
    logic [W-1:0] e;
    for (int k = 0; k < 2**N_IN; k++) exp_q.push_back(ref_fn(N_IN'(k)));
    bus.sweep_start = 1'b1;
    tick();
    bus.sweep_start = 1'b0;
    check_eq("sw_start_busy", 32'(bus.busy), 32'd1);
    check_eq("sw_start_cnt", 32'(bus.minterm_cnt), 32'd0);
    check_eq("sw_start_valid", 32'(bus.out_valid), 32'd0);
    for (int k = 0; k < 2**N_IN; k++) begin
      if (inject && k == 5) begin
        bus.cfg_we = 1'b1; bus.cfg_addr = 4'h3; bus.cfg_data = 3'b000;
        bus.in_valid = 1'b1; bus.in_vec = 4'h9; bus.sweep_start = 1'b1;
      end
      tick();
      idle_inputs();
      check_eq("sw_valid", 32'(bus.out_valid), 32'd1);
      check_eq("sw_idx", 32'(bus.out_idx), 32'(k));
      check_eq("sw_busy", 32'(bus.busy), 32'd1);
      check_eq("sw_done_early", 32'(bus.sweep_done), 32'd0);
      if (exp_q.size() == 0) begin
        check_eq("sw_queue_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sw_vec", 32'(bus.out_vec), 32'(e));
      end
    end
    check_eq("sw_cnt", 32'(bus.minterm_cnt), 32'({5'd16, 5'd4, 5'd8}));
    tick();
    check_eq("sw_done_pulse", 32'(bus.sweep_done), 32'd1);
    check_eq("sw_done_busy", 32'(bus.busy), 32'd0);
    check_eq("sw_done_valid", 32'(bus.out_valid), 32'd0);
    check_eq("sw_cnt_hold", 32'(bus.minterm_cnt), 32'({5'd16, 5'd4, 5'd8}));
    eval_check("post_sweep_eval", 4'hD, 3'b111);
    check_eq("sw_done_drop", 32'(bus.sweep_done), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_vec", 32'(bus.out_vec), 32'd0);
    check_eq("rst_idx", 32'(bus.out_idx), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.sweep_done), 32'd0);
    check_eq("rst_cnt", 32'(bus.minterm_cnt), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);

    eval_check("first_eval", 4'hA, 3'b000);
    check_eq("first_busy", 32'(bus.busy), 32'd0);
    check_eq("first_done", 32'(bus.sweep_done), 32'd0);
    tick();
    check_eq("valid_drop", 32'(bus.out_valid), 32'd0);
    check_eq("idx_hold", 32'(bus.out_idx), 32'hA);

    for (int a = 0; a < 2**N_IN; a++) write_entry(N_IN'(a), ref_fn(N_IN'(a)));
    eval_check("eval_D", 4'hD, 3'b111);
    eval_check("eval_6", 4'h6, 3'b100);

    run_sweep(1'b0);
    run_sweep(1'b1);
    eval_check("table_kept_3", 4'h3, 3'b101);
    exp_q.delete();

    write_entry(4'h5, 3'b101);
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'h5; bus.cfg_data = 3'b010;
    eval_check("rbw_old", 4'h5, 3'b101);
    bus.cfg_we = 1'b0;
    eval_check("rbw_new", 4'h5, 3'b010);

    bus.sweep_start = 1'b1;
    tick();
    bus.sweep_start = 1'b0;
    repeat (8) tick();
    check_eq("mid_idx7", 32'(bus.out_idx), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(bus.busy), 32'd0);
    check_eq("arst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("arst_cnt", 32'(bus.minterm_cnt), 32'd0);
    check_eq("arst_state", 32'(dbg_state), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    eval_check("arst_eval", 4'hD, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/funcion_lut_seq.md
# funcion_lut_seq

Parametrised, registered truth-table evaluator: a generalisation of the fixed 4-input, hand-written boolean-function blocks of the practice guides. The block holds a runtime-loadable table of N_OUT boolean functions of N_IN inputs. It evaluates single input vectors with one-cycle latency. It also has a sweep mode that walks every input combination, streams the results and counts the minterms (ones) of each output function.

## Interface
- N_IN, 4, number of function inputs (1..8); table depth is 2**N_IN
- N_OUT, 3, number of output functions (1..16)
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  write one table entry
- cfg_addr  in  N_IN  table entry (input combination) to write
- cfg_data  in  N_OUT  output bits for that entry; bit j = function j
- in_valid  in  1  evaluate in_vec
- in_vec  in  N_IN  input combination to evaluate
- sweep_start  in  1  start an exhaustive sweep
- out_valid  out  1  out_vec/out_idx valid this cycle
- out_vec  out  N_OUT  function outputs for out_idx
- out_idx  out  N_IN  input combination that produced out_vec
- busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse at the end of a sweep
- minterm_cnt  out  N_OUT*(N_IN+1)  per-function count of ones; field j = bits [j*(N_IN+1) +: N_IN+1]

## Operation
- Storage: 2**N_IN x N_OUT register array. Reset clears every entry to 0.
- FSM states: IDLE, SWEEP, DONE.
- IDLE behaviour:
  - cfg_we writes table[cfg_addr] <= cfg_data.
  - in_valid registers out_vec <= table[in_vec] and out_idx <= in_vec, and sets out_valid.
  - Same-cycle cfg_we and in_valid at the same address: the read returns the old contents (read-before-write); the write still takes effect.
- sweep_start in IDLE:
  - Moves the FSM to SWEEP, sets busy, clears all minterm_cnt fields and sets idx to 0.
  - sweep_start has priority over in_valid in the same cycle. A same-cycle cfg_we is still performed.
- SWEEP, on each edge:
  - out_vec <= table[idx], out_idx <= idx, out_valid <= 1.
  - Field j of minterm_cnt increments by table[idx][j].
  - idx increments. Processing idx = 2**N_IN-1 moves the FSM to DONE.
- DONE, on the next edge: sweep_done <= 1 for exactly one cycle, busy <= 0, FSM returns to IDLE.
- While busy: cfg_we, in_valid and sweep_start are ignored (dropped, not queued).
- minterm_cnt holds its value after the sweep until the next sweep_start or reset. Width N_IN+1 holds the full count 2**N_IN without wrap. idx is an N_IN+1-bit counter, so there is no wrap-around inside a sweep.
- Reset asserted at any time, including mid-sweep, forces the reset values immediately, independent of clk.

## Timing
- Reset values: out_valid=0, out_vec=0, out_idx=0, busy=0, sweep_done=0, minterm_cnt=0, FSM=IDLE, table all 0.
- Evaluation latency is 1 cycle: in_valid sampled at edge E gives out_valid high after E for one cycle, unless in_valid is sampled again.
- out_valid is a pulse per accepted request. With no request it drops to 0; out_vec/out_idx hold their last values.
- A write at edge E is visible to an evaluation sampled at edge E+1.
- Sweep, with sweep_start sampled at edge E0:
  - busy is high from E0 until E(2**N_IN+1).
  - Entry k is presented after edge E(k+1). out_valid is continuously high for 2**N_IN cycles.
  - minterm_cnt is final after E(2**N_IN).
  - sweep_done is high for the single cycle after E(2**N_IN+1); busy is already 0 in that cycle.
- The earliest new request is accepted at the edge after sweep_done, i.e. E(2**N_IN+2).

## Test plan
- Reset, then in_valid with in_vec=4'hA, N_IN=4, N_OUT=3 → next cycle out_valid=1, out_vec=3'b000, out_idx=4'hA; all other outputs are at their reset values.
- Load 16 entries with bit0=in[0], bit1=in[3]&in[2], bit2=1. Evaluate in_vec=4'hD → out_vec=3'b111. Evaluate in_vec=4'h6 → out_vec=3'b100.
- Sweep with the table above → 16 consecutive out_valid cycles with out_idx 0..15. minterm_cnt fields are 8, 4, 16; the value 16 checks the no-overflow width. sweep_done pulses once, 17 edges after start, and busy falls on the same edge.
- Same-cycle cfg_we (addr 5, data 3'b010) and in_valid (in_vec 5) after loading 3'b101 at 5 → out_vec=3'b101. A following read of 5 → 3'b010.
- Mid-sweep cfg_we, in_valid and sweep_start → all ignored: sequence, counts and table are unchanged and no extra out_valid appears.
- rst_n pulled low at sweep entry 7, asynchronously → busy, out_valid and minterm_cnt go to 0 at once. After release, an evaluation of any address returns 0.
